// File: rtl/score_bcd.sv
`default_nettype none
// ============================================================================
//  Module   : score_bcd
//  Purpose  : Converts a signed 32-bit running score into four BCD digits,
//             a sign flag and a saturation flag. Magnitude is clamped to
//             MAX_VALUE and converted with a 14-step double-dabble.
//             A conversion is started whenever the score differs from the
//             last captured value, so the final stable score is always shown.
//  Ports    : Clk      - system clock, all state on rising edge
//             Reset    - synchronous, active-high reset
//             score    - signed running score
//             busy     - high while a conversion is in progress
//             valid    - one-cycle pulse when new digits are published
//             digits   - {thousands, hundreds, tens, units} BCD nibbles
//             negative - sign of the last converted score
//             overflow - last converted magnitude exceeded MAX_VALUE
//             hex0..3  - active-low 7-segment patterns (bit0=a..bit6=g)
//                        for digits[3:0]..digits[15:12]; present only when
//                        SCORE_BCD_SEG_EN is defined
//  Options  : SCORE_BCD_SEG_EN - adds registered 7-segment outputs
//  Revision : 1.0 - initial release
// ============================================================================
module score_bcd #(
   parameter int MAX_VALUE = 9999
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic signed [31:0] score,
   output logic               busy,
   output logic               valid,
   output logic [15:0]        digits,
   output logic               negative,
   output logic               overflow
`ifdef SCORE_BCD_SEG_EN
   ,
   output logic [6:0]         hex0,
   output logic [6:0]         hex1,
   output logic [6:0]         hex2,
   output logic [6:0]         hex3
`endif
);

   localparam logic [1:0]  c_IDLE  = 2'd0;
   localparam logic [1:0]  c_LOAD  = 2'd1;
   localparam logic [1:0]  c_SHIFT = 2'd2;
   localparam logic [1:0]  c_DONE  = 2'd3;

   localparam logic [32:0] c_MAX_WIDE = 33'(MAX_VALUE);
   localparam logic [13:0] c_MAX_MAG  = 14'(MAX_VALUE);
   localparam logic [3:0]  c_LAST_SHIFT = 4'd13;

   logic [1:0]  r_state;
   logic [31:0] r_snapshot;
   logic [31:0] r_last_score;
   logic        r_pending;
   logic        r_sign;
   logic        r_ovf_flag;
   logic [13:0] r_shift;
   logic [15:0] r_acc;
   logic [3:0]  r_cnt;
   logic [15:0] r_digits;
   logic        r_negative;
   logic        r_overflow;
   logic        r_valid;

   // Absolute value is formed in 33 bits so that -2^31 stays positive.
   logic [32:0] w_ext;
   logic [32:0] w_abs;
   logic        w_over;
   logic [13:0] w_mag;
   logic [15:0] w_adj;

   assign w_ext  = {r_snapshot[31], r_snapshot};
   assign w_abs  = r_snapshot[31] ? (~w_ext + 33'd1) : w_ext;
   assign w_over = (w_abs > c_MAX_WIDE);
   assign w_mag  = w_over ? c_MAX_MAG : w_abs[13:0];

   // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
   generate
      for (genvar i = 0; i < 4; i++) begin : g_adj
         assign w_adj[4*i +: 4] = (r_acc[4*i +: 4] >= 4'd5) ?
                                  (r_acc[4*i +: 4] + 4'd3) : r_acc[4*i +: 4];
      end
   endgenerate

`ifdef SCORE_BCD_SEG_EN
   logic [6:0] r_hex0;
   logic [6:0] r_hex1;
   logic [6:0] r_hex2;
   logic [6:0] r_hex3;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction
`endif

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state      <= c_IDLE;
         r_snapshot   <= 32'd0;
         r_last_score <= 32'd0;
         r_pending    <= 1'b1;
         r_sign       <= 1'b0;
         r_ovf_flag   <= 1'b0;
         r_shift      <= 14'd0;
         r_acc        <= 16'd0;
         r_cnt        <= 4'd0;
         r_digits     <= 16'h0000;
         r_negative   <= 1'b0;
         r_overflow   <= 1'b0;
         r_valid      <= 1'b0;
`ifdef SCORE_BCD_SEG_EN
         r_hex0       <= 7'b1000000;
         r_hex1       <= 7'b1000000;
         r_hex2       <= 7'b1000000;
         r_hex3       <= 7'b1000000;
`endif
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            c_IDLE: begin
               // pending forces one conversion after reset even if unchanged
               if ((score != r_last_score) || r_pending) begin
                  r_snapshot   <= score;
                  r_last_score <= score;
                  r_pending    <= 1'b0;
                  r_state      <= c_LOAD;
               end
            end
            c_LOAD: begin
               r_sign     <= r_snapshot[31];
               r_ovf_flag <= w_over;
               r_acc      <= 16'd0;
               r_shift    <= w_mag;
               r_cnt      <= 4'd0;
               r_state    <= c_SHIFT;
            end
            c_SHIFT: begin
               r_acc   <= {w_adj[14:0], r_shift[13]};
               r_shift <= {r_shift[12:0], 1'b0};
               r_cnt   <= r_cnt + 4'd1;
               if (r_cnt == c_LAST_SHIFT) begin
                  r_state <= c_DONE;
               end
            end
            c_DONE: begin
               r_digits   <= r_acc;
               r_negative <= r_sign;
               r_overflow <= r_ovf_flag;
               r_valid    <= 1'b1;
`ifdef SCORE_BCD_SEG_EN
               r_hex0     <= seg7(r_acc[3:0]);
               r_hex1     <= seg7(r_acc[7:4]);
               r_hex2     <= seg7(r_acc[11:8]);
               r_hex3     <= seg7(r_acc[15:12]);
`endif
               r_state    <= c_IDLE;
            end
            default: r_state <= c_IDLE;
         endcase
      end
   end

   assign busy     = (r_state != c_IDLE);
   assign valid    = r_valid;
   assign digits   = r_digits;
   assign negative = r_negative;
   assign overflow = r_overflow;
`ifdef SCORE_BCD_SEG_EN
   assign hex0 = r_hex0;
   assign hex1 = r_hex1;
   assign hex2 = r_hex2;
   assign hex3 = r_hex3;
`endif

endmodule
`default_nettype wire

// File: tb/tb_score_bcd.sv
`default_nettype none
// ============================================================================
//  Module   : tb_score_bcd
//  Purpose  : Self-checking bench for score_bcd. Expected results are queued
//             when a conversion is provoked and popped by a monitor on each
//             valid pulse; outputs are also checked to hold between pulses
//             and to be cleared during reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_score_bcd;

   localparam int MAX = 9999;

   logic               Clk = 1'b0;
   logic               Reset = 1'b1;
   logic signed [31:0] score = 32'sd100;
   logic               busy;
   logic               valid;
   logic [15:0]        digits;
   logic               negative;
   logic               overflow;
`ifdef SCORE_BCD_SEG_EN
   logic [6:0]         hex0, hex1, hex2, hex3;
`endif

   score_bcd #(.MAX_VALUE(MAX)) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .score    (score),
      .busy     (busy),
      .valid    (valid),
      .digits   (digits),
      .negative (negative),
      .overflow (overflow)
`ifdef SCORE_BCD_SEG_EN
      ,
      .hex0     (hex0),
      .hex1     (hex1),
      .hex2     (hex2),
      .hex3     (hex3)
`endif
   );

   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;

   // expected {overflow, negative, digits}
   logic [17:0] exp_q[$];
   logic [17:0] hold_exp = 18'd0;
   bit          rst_seen = 1'b0;

   always @(posedge Clk) rst_seen <= Reset;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Reference: plain decimal arithmetic on the saturated magnitude.
   function automatic logic [17:0] model(input int v);
      longint mag;
      logic   ovf;
      logic [15:0] d;
      mag = v;
      if (mag < 0) mag = -mag;
      ovf = (mag > MAX);
      if (ovf) mag = MAX;
      d[15:12] = 4'((mag / 1000) % 10);
      d[11:8]  = 4'((mag / 100) % 10);
      d[7:4]   = 4'((mag / 10) % 10);
      d[3:0]   = 4'(mag % 10);
      return {ovf, (v < 0), d};
   endfunction

`ifdef SCORE_BCD_SEG_EN
   function automatic logic [6:0] seg_ref(input logic [3:0] d);
      logic [6:0] tbl [10];
      tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
      return (d < 4'd10) ? tbl[d] : 7'b1111111;
   endfunction
`endif

   // Monitor / scoreboard
   always @(negedge Clk) begin
      if (rst_seen) begin
         chk("reset_state", {busy, valid, negative, overflow, digits}, 20'h0);
         hold_exp = 18'd0;
      end else if (valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_valid", {overflow, negative, digits}, 18'h3ffff);
         end else begin
            hold_exp = exp_q.pop_front();
            chk("published", {overflow, negative, digits}, hold_exp);
`ifdef SCORE_BCD_SEG_EN
            chk("hex", {hex3, hex2, hex1, hex0},
                {seg_ref(hold_exp[15:12]), seg_ref(hold_exp[11:8]),
                 seg_ref(hold_exp[7:4]), seg_ref(hold_exp[3:0])});
`endif
         end
      end else begin
         chk("hold", {overflow, negative, digits}, hold_exp);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge Clk);
      #2;
   endtask

   task automatic apply(input int v, input bit conv);
      score = v;
      if (conv) exp_q.push_back(model(v));
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < 100) begin
         tick(1);
         n++;
      end
      if (n >= 100) begin
         chk("drain_timeout", 64'(exp_q.size()), 64'd0);
         exp_q.delete();
      end
   endtask

   function automatic int rand_score();
      case ($urandom_range(0, 9))
         0:       return 32'sh80000000;
         1:       return 32'sh7fffffff;
         2, 3, 4, 5: return int'($urandom_range(0, 30000)) - 15000;
         default: return int'($urandom_range(0, 9999));
      endcase
   endfunction

   initial begin
      int n;
      int v1, v2;
      // Reset with score=100 and check latency from release
      exp_q.push_back(model(100));
      tick(2);
      Reset = 1'b0;
      n = 0;
      do begin
         tick(1);
         n++;
      end while (!valid && n < 40);
      chk("latency", 64'(n), 64'd17);
      wait_drain();

      // 100 -> 130 -> 110 with idle gaps
      apply(130, 1'b1); wait_drain(); tick(40);
      apply(110, 1'b1); wait_drain(); tick(40);

      // sign / saturation cases
      apply(-20, 1'b1);              wait_drain();
      apply(12345, 1'b1);            wait_drain();
      apply(32'sh80000000, 1'b1);    wait_drain();
      apply(100, 1'b1);              wait_drain();

      // mid-conversion change: 120 then 150 three cycles later
      apply(120, 1'b1);
      tick(3);
      apply(150, 1'b1);
      n = 0;
      do begin
         tick(1);
         n++;
      end while (!valid && n < 40);
      chk("gap_busy_low", {31'd0, busy, 32'(n < 40)}, 64'd1);
      tick(1);
      chk("gap_busy_back", 64'(busy), 64'd1);
      wait_drain();

      // return to last captured value during busy: no extra conversion
      apply(777, 1'b1);
      tick(2);
      apply(778, 1'b0);
      tick(2);
      apply(777, 1'b0);
      wait_drain();
      tick(5);

      // reset during SHIFT with score=250
      apply(250, 1'b1);
      tick(6);
      chk("busy_before_reset", 64'(busy), 64'd1);
      Reset = 1'b1;
      exp_q.delete();
      exp_q.push_back(model(250));
      tick(2);
      Reset = 1'b0;
      wait_drain();

`ifdef SCORE_BCD_SEG_EN
      apply(1234, 1'b1);
      wait_drain();
      chk("hex_1234", {hex3, hex2, hex1, hex0},
          {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});
`endif

      // randomized traffic
      for (int it = 0; it < 40; it++) begin
         do v1 = rand_score(); while (v1 == score);
         apply(v1, 1'b1);
         case ($urandom_range(0, 2))
            0: ;
            1: begin
               tick($urandom_range(1, 12));
               v2 = ($urandom_range(0, 2) == 0) ? v1 : rand_score();
               apply(v2, v2 != v1);
            end
            default: begin
               tick($urandom_range(1, 6));
               do v2 = rand_score(); while (v2 == v1);
               apply(v2, 1'b0);
               tick(3);
               apply(v1, 1'b0);
            end
         endcase
         wait_drain();
         tick($urandom_range(0, 3));
      end

      tick(5);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, time %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/score_bcd.md
SCORE_BCD -- requirements
Module: score_bcd

Interface
REQ-001 SHALL have parameter MAX_VALUE, default 9999, magnitude saturation ceiling; legal range 1..9999.
REQ-002 SHALL have port Clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port score  input  32  signed running score from the score counter.
REQ-005 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-006 SHALL have port valid  output  1  one-cycle pulse when new digits are published.
REQ-007 SHALL have port digits  output  16  four BCD nibbles; [15:12] thousands ... [3:0] units.
REQ-008 SHALL have port negative  output  1  sign of the last converted score.
REQ-009 SHALL have port overflow  output  1  last converted magnitude exceeded MAX_VALUE.

Function
REQ-010 SHALL implement FSM states IDLE, LOAD, SHIFT, DONE.
REQ-011 In IDLE, when score differs from last_score or the pending flag is set, SHALL capture score into snapshot and last_score, clear pending, and go to LOAD.
REQ-012 In LOAD, SHALL set sign = snapshot[31], magnitude = |snapshot| clamped to MAX_VALUE, overflow flag = |snapshot| > MAX_VALUE, clear the BCD accumulator, load a 14-bit shift register with the magnitude, go to SHIFT.
REQ-013 |snapshot| SHALL be computed in 33 bits, so -2147483648 yields overflow=1 and magnitude MAX_VALUE.
REQ-014 In SHIFT, each cycle SHALL add 3 to every BCD nibble >= 5, then shift one bit MSB-first from the shift register into the accumulator; exactly 14 SHIFT cycles, then DONE.
REQ-015 In DONE, SHALL register accumulator to digits, sign to negative, flag to overflow, assert valid for that one cycle only, return to IDLE.
REQ-016 Latency SHALL be 17 rising edges from the capturing edge to the edge that updates digits; valid high in the cycle after that edge.
REQ-017 busy SHALL be high in LOAD, SHIFT, DONE and low in IDLE.
REQ-018 score changes during busy SHALL NOT disturb the running conversion; the next IDLE cycle SHALL detect the difference and start a new conversion, so the final stable score is always published.
REQ-019 A score returning to the last captured value during busy SHALL cause no further conversion.
REQ-020 digits, negative, overflow SHALL hold between valid pulses.

Reset
REQ-021 Reset SHALL take priority over all state and force IDLE, digits=16'h0000, valid=0, busy=0, negative=0, overflow=0, pending=1.
REQ-022 Reset mid-conversion SHALL abort without publishing; the cycle after Reset deasserts, IDLE SHALL convert the current score unconditionally via pending.

Configuration
REQ-023 Macro SCORE_BCD_SEG_EN SHALL, when defined, add outputs hex0..hex3 (7 bits each, active-low, bit0=a ... bit6=g, standard 0-9 patterns) decoding digits[3:0]..digits[15:12], registered on the same edge as digits, reset to the "0" pattern 7'b1000000.
REQ-024 Without SCORE_BCD_SEG_EN, hex0..hex3 SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-025 Reset held 2 cycles with score=100, then released -> valid pulses 17 edges after first IDLE edge; digits=16'h0100, negative=0, overflow=0.
REQ-026 score steps 100 -> 130 -> 110 with 40 idle cycles between -> two valid pulses, digits 16'h0130 then 16'h0110.
REQ-027 score=-20 -> digits=16'h0020, negative=1, overflow=0; score=12345 -> digits=16'h9999, overflow=1; score=-2147483648 -> 16'h9999, negative=1, overflow=1.
REQ-028 score 100 -> 120 then 150 three cycles later (mid-conversion) -> first pulse digits 16'h0120, second pulse 16'h0150, busy never glitches low between conversions except one IDLE cycle.
REQ-029 Reset asserted during SHIFT with score=250 -> no valid pulse, digits=16'h0000 during reset, then digits 16'h0250 after conversion.
REQ-030 With SCORE_BCD_SEG_EN, score=1234 -> hex3=7'b1111001, hex2=7'b0100100, hex1=7'b0110000, hex0=7'b0011001.
